counter_seq_ctrl: RTL
=====================

Name: counter_seq_ctrl

Overview:
Sequencer for the 4-bit enable-gated counter macro. It drives the counter's rst, en and clkEn pins and watches its co output. It generates a programmable clkEn tick rate, counts a programmed number of counter wrap events (epochs), then reports completion with a start/busy/done handshake. One-shot and auto-reload modes are supported, and a run can be aborted at any time.

Parameters:
PRESCALE_W, 8, width of the prescale divider value and internal prescale counter
EPOCH_W, 8, width of the epoch target and epoch counter

Ports:
clk  in  1  single system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request a run; sampled only in IDLE
abort  in  1  terminate the current run; sampled in every non-IDLE state
auto_reload  in  1  latched at start; 1 = restart after DONE
prescale  in  PRESCALE_W  latched at start; one tick every prescale+1 RUN cycles
epochs  in  EPOCH_W  latched at start; number of counter wraps per run (0 is illegal)
cnt_co  in  1  counter terminal-count level (co pin of counter macro)
cnt_rst  out  1  to counter rst
cnt_en  out  1  to counter en
cnt_clkEn  out  1  to counter clkEn (tick)
busy  out  1  high in CLEAR, RUN, DONE
done  out  1  one-cycle pulse per completed run
aborted  out  1  one-cycle pulse when a run is aborted
err  out  1  one-cycle pulse when start is rejected
epoch_cnt  out  EPOCH_W  wraps completed in the current run

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; the prescale counter, epoch_cnt and latched config are cleared. busy, done, aborted, err and cnt_en are 0. cnt_rst = rst OR (state==CLEAR), so the counter macro is held in reset together with this block.
- States: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - start=1 and epochs!=0 and abort=0: latch prescale, epochs and auto_reload; go to CLEAR.
  - start=1 and epochs==0: err=1 for the next cycle; stay in IDLE.
  - start=1 and abort=1 in the same cycle: no-op; stay in IDLE with no err.
- CLEAR: lasts exactly one cycle with cnt_rst=1. The prescale counter and epoch_cnt are zeroed. Go to RUN.
- RUN:
  - cnt_en=1.
  - tick = (presc==prescale_q); cnt_clkEn=tick, decoded combinationally from registers.
  - On tick, presc returns to 0; otherwise presc increments.
  - epoch_event = tick AND cnt_co. It increments epoch_cnt.
  - When epoch_event occurs and epoch_cnt+1==epochs_q, go to DONE.
- DONE: lasts one cycle. done=1 and cnt_en=0. Next state is CLEAR if auto_reload_q=1, otherwise IDLE. epoch_cnt holds its final value until the next CLEAR.
- abort=1 in CLEAR, RUN or DONE:
  - next state is IDLE and aborted=1 for one cycle;
  - cnt_en drops on the next cycle; no done is produced, even if the final epoch_event occurs in the same cycle.
  - abort during DONE: done still shows in that cycle, and auto-reload is cancelled.
- start while busy: ignored; no err.
- Config inputs are ignored outside the IDLE start edge; changes mid-run have no effect.
- Width rules: presc and epoch_cnt are unsigned. The epoch_cnt+1 compare uses EPOCH_W+1 bits. epochs=2^EPOCH_W-1 is the maximum target.
- prescale=0 gives cnt_clkEn=1 on every RUN cycle.
- Latency: done asserts exactly 1 + (prescale+1)*16*epochs + 1 cycles after the edge at which start is accepted. This assumes a mod-16 counter with co at count 15.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, CLEAR, RUN, DONE);
  - default widths PRESCALE_W and EPOCH_W;
  - the EPOCHS_ILLEGAL constant (0).
- One natural sub-module: counter_tick_gen, containing the prescale counter, the tick compare, and the clear/enable inputs.
- The FSM, epoch counter and handshake stay in the top level.

Test Plan:
- Reset: assert rst 3 cycles mid-RUN -> state IDLE, cnt_rst=1 while rst=1, busy/done/cnt_en=0, epoch_cnt=0.
- One-shot, fast: prescale=0, epochs=1, mod-16 counter model -> cnt_rst high for 1 cycle, 16 cnt_clkEn pulses, done pulse 18 cycles after start, then IDLE.
- Prescaled, two epochs: prescale=3, epochs=2 -> cnt_clkEn every 4th cycle, epoch_cnt 0->1->2, done at cycle 130, busy low at 131.
- Auto-reload: prescale=0, epochs=1, auto_reload=1 -> done pulses at cycles 18, 36, 54. Assert abort at cycle 40 -> aborted pulse, IDLE, no further done.
- Boundary handshake: epochs=0 with start -> err pulse, no busy. start+abort together in IDLE -> nothing happens. start during RUN -> ignored. abort in the cycle of the final epoch_event -> aborted=1, done=0.

Source files
------------

// File: rtl/counter_seq_ctrl_pkg.sv
// Shared types and constants for the counter sequencer: FSM states,
// default widths and the illegal epoch target.
package counter_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_PRESCALE_W = 8;
  localparam int DEF_EPOCH_W    = 8;
  localparam int EPOCHS_ILLEGAL = 0;

endpackage

// File: rtl/counter_seq_ctrl_tick_gen.sv
// Prescale divider: emits one tick every prescale+1 enabled cycles,
// restarting from zero whenever it is cleared.
module counter_seq_ctrl_tick_gen #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_en,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic                  o_tick
);

  logic [PRESCALE_W-1:0] r_presc;
  logic                  w_hit;

  assign w_hit  = (r_presc == i_prescale);
  assign o_tick = i_en & w_hit;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_presc <= '0;
    end else if (i_en) begin
      if (w_hit) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PRESCALE_W'(1);
      end
    end
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencer for the 4-bit enable-gated counter macro: paces its clkEn,
// counts wrap events and reports completion via start/busy/done.
module counter_seq_ctrl
  import counter_seq_ctrl_pkg::*;
#(
  parameter int PRESCALE_W = DEF_PRESCALE_W,
  parameter int EPOCH_W    = DEF_EPOCH_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  auto_reload,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [EPOCH_W-1:0]    epochs,
  input  logic                  cnt_co,
  output logic                  cnt_rst,
  output logic                  cnt_en,
  output logic                  cnt_clkEn,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  err,
  output logic [EPOCH_W-1:0]    epoch_cnt
);

  state_t                r_state;
  state_t                w_state_next;
  logic [PRESCALE_W-1:0] r_prescale_q;
  logic [EPOCH_W-1:0]    r_epochs_q;
  logic [EPOCH_W-1:0]    r_epoch_cnt;
  logic                  r_auto_reload_q;
  logic                  r_aborted;
  logic                  r_err;

  logic                  w_idle;
  logic                  w_run;
  logic                  w_tick;
  logic                  w_epoch_event;
  logic                  w_last_epoch;
  logic                  w_epochs_zero;
  logic                  w_start_ok;
  logic                  w_start_bad;
  logic                  w_abort_run;
  logic [EPOCH_W:0]      w_epoch_inc;

  assign w_idle        = (r_state == ST_IDLE);
  assign w_run         = (r_state == ST_RUN);
  assign w_epochs_zero = (epochs == EPOCH_W'(EPOCHS_ILLEGAL));
  assign w_start_ok    = w_idle & start & ~abort & ~w_epochs_zero;
  assign w_start_bad   = w_idle & start & ~abort & w_epochs_zero;
  assign w_abort_run   = ~w_idle & abort;
  assign w_epoch_event = w_run & w_tick & cnt_co;
  // One extra bit so the target compare cannot alias at the maximum epoch count.
  assign w_epoch_inc   = {1'b0, r_epoch_cnt} + (EPOCH_W + 1)'(1);
  assign w_last_epoch  = (w_epoch_inc == {1'b0, r_epochs_q});

  counter_seq_ctrl_tick_gen #(
    .PRESCALE_W (PRESCALE_W)
  ) u_tick_gen (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (r_state == ST_CLEAR),
    .i_en       (w_run),
    .i_prescale (r_prescale_q),
    .o_tick     (w_tick)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_ok) w_state_next = ST_CLEAR;
      ST_CLEAR: w_state_next = ST_RUN;
      ST_RUN:   if (w_epoch_event && w_last_epoch) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = r_auto_reload_q ? ST_CLEAR : ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
    // Abort wins over completion and over auto-reload.
    if (w_abort_run) begin
      w_state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_prescale_q    <= '0;
      r_epochs_q      <= '0;
      r_auto_reload_q <= 1'b0;
      r_epoch_cnt     <= '0;
      r_aborted       <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_aborted <= w_abort_run;
      r_err     <= w_start_bad;
      if (w_start_ok) begin
        r_prescale_q    <= prescale;
        r_epochs_q      <= epochs;
        r_auto_reload_q <= auto_reload;
      end
      if (r_state == ST_CLEAR) begin
        r_epoch_cnt <= '0;
      end else if (w_epoch_event) begin
        r_epoch_cnt <= w_epoch_inc[EPOCH_W-1:0];
      end
    end
  end

  assign cnt_rst   = rst | (r_state == ST_CLEAR);
  assign cnt_en    = w_run;
  assign cnt_clkEn = w_tick;
  assign busy      = ~w_idle;
  assign done      = (r_state == ST_DONE);
  assign aborted   = r_aborted;
  assign err       = r_err;
  assign epoch_cnt = r_epoch_cnt;

endmodule
